issue_unit: RTL and testbench
=============================

Name: issue_unit

Overview:
- Tomasulo issue stage sitting directly downstream of the dispatch reservation stations (int, mem, mult, div).
- Each cycle, grants issue to any ready station whose functional unit can accept work and whose result slot on the single Common Data Bus (CDB) is free.
- Keeps a CDB reservation shift register so that at most one unit drives the CDB per cycle.
- Drives the per-station issue-done pulses and the CDB source select.

Parameters:
- INT_LAT, 1, cycles from int issue to int result on CDB
- MEM_LAT, 2, cycles from mem issue to load result on CDB
- MULT_LAT, 4, multiplier latency; pipelined, can accept one op per cycle
- DIV_LAT, 7, divider latency; not pipelined
- Constraint: 1 <= INT_LAT < MEM_LAT < MULT_LAT < DIV_LAT <= 15. The latencies are all distinct, so no two grants ever target the same slot.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset, sampled on rising i_clk
- int_issue_rdy  in  1  int reservation station holds an operand-ready entry
- mem_issue_rdy  in  1  load/store queue head is ready
- mult_issue_rdy  in  1  mult reservation station holds a ready entry
- div_issue_rdy  in  1  div reservation station holds a ready entry
- issue_done_int  out  1  grant to int station; the station pops its entry this cycle
- issue_done_mem  out  1  grant to mem queue
- issue_done_mult  out  1  grant to mult station
- issue_done_div  out  1  grant to div station
- div_busy  out  1  divider occupied; no div grant possible
- cdb_sel_valid  out  1  a unit drives the CDB this cycle
- cdb_sel  out  2  CDB source this cycle: 0=int, 1=mem, 2=mult, 3=div
- cdb_slot_vec  out  DIV_LAT+1  CDB reservation map, debug/verification visibility

Behaviour:
- State:
  - slot[0..DIV_LAT]: slot[k]=1 means the CDB is booked k cycles from now.
  - own[0..DIV_LAT]: 2-bit source ID for each slot.
  - div_cnt: 4-bit divider countdown.
- Grant logic is combinational, evaluated in the same cycle as rdy (zero latency):
  - issue_done_X = X_issue_rdy & ~slot[X_LAT].
  - issue_done_div additionally requires ~div_busy.
  - Several grants in one cycle are legal. Distinct latencies guarantee distinct slots, so no priority logic is needed.
- Slot update every cycle:
  - slot'[k] = slot[k+1] for k < DIV_LAT; slot'[DIV_LAT] = 0. own shifts the same way.
  - A grant of unit X additionally sets slot'[X_LAT-1]=1 and own'[X_LAT-1]=ID(X).
  - Net effect: a grant at cycle t places the result on the CDB at cycle t+X_LAT.
  - When INT_LAT=1, an int grant sets slot'[0] directly.
- CDB outputs:
  - cdb_sel_valid = slot[0]; cdb_sel = own[0].
  - cdb_sel = 0 whenever cdb_sel_valid = 0.
- Divider:
  - A div grant loads div_cnt = DIV_LAT-1.
  - div_cnt decrements while nonzero; div_busy = (div_cnt != 0).
  - Result: back-to-back div grants are spaced exactly DIV_LAT cycles apart.
- Mult is pipelined: a mult grant is possible on every cycle in which slot[MULT_LAT]=0.
- Idle: no rdy means no grant, and slots simply drain.
- A rdy that arrives while its slot is booked keeps its grant low. The grant follows on the first cycle the slot is free. The station must hold rdy high; no request state is stored here.
- Reset (i_rst_n=0 at a clock edge), including mid-operation:
  - slot, own and div_cnt clear to 0.
  - All in-flight reservations are discarded.
  - While i_rst_n=0, issue_done_* are forced to 0.
  - First cycle after reset: cdb_sel_valid=0, cdb_sel=0, div_busy=0, cdb_slot_vec=0.

Test Plan:
- Reset: hold i_rst_n=0 for 3 cycles with all rdy=1 -> every issue_done_*=0, cdb_sel_valid=0, cdb_slot_vec=0.
- All four rdy=1 at cycle t, slots empty -> all four issue_done high at t; then:
  - cdb_sel_valid=1 at t+1 (cdb_sel=0), t+2 (1), t+4 (2), t+7 (3);
  - cdb_sel_valid=0 at t+3, t+5, t+6.
- Mult granted at t; int_issue_rdy=1 from t+3 -> issue_done_int=0 at t+3 (slot 1 booked by mult). Int is granted at t+4, mult drives the CDB at t+4 (cdb_sel=2), and int drives it at t+5 (cdb_sel=0).
- div_issue_rdy held at 1 -> div grants at t, t+7, t+14; div_busy=1 during t+1..t+6; cdb_sel=3 at t+7, t+14.
- mult_issue_rdy held at 1 for 5 cycles from t -> five consecutive mult grants; cdb_sel_valid=1 with cdb_sel=2 at t+4..t+8.
- Mult and div granted at t, then i_rst_n=0 at t+2 -> cdb_slot_vec=0 from t+3, div_busy=0, no cdb_sel_valid at t+4 or t+7.

Source files
------------

// File: rtl/issue_unit_if.sv
// Issue-stage bus: reservation-station ready lines in, grants and CDB source select out.
// The issue unit takes the slave side; the dispatch/RS side (or a bench) takes master.
interface issue_unit_if #(
   parameter int DIV_LAT = 7
);
   logic               int_issue_rdy;
   logic               mem_issue_rdy;
   logic               mult_issue_rdy;
   logic               div_issue_rdy;
   logic               issue_done_int;
   logic               issue_done_mem;
   logic               issue_done_mult;
   logic               issue_done_div;
   logic               div_busy;
   logic               cdb_sel_valid;
   logic [1:0]         cdb_sel;
   logic [DIV_LAT:0]   cdb_slot_vec;

   modport slave (
      input  int_issue_rdy, mem_issue_rdy, mult_issue_rdy, div_issue_rdy,
      output issue_done_int, issue_done_mem, issue_done_mult, issue_done_div,
             div_busy, cdb_sel_valid, cdb_sel, cdb_slot_vec
   );

   modport master (
      output int_issue_rdy, mem_issue_rdy, mult_issue_rdy, div_issue_rdy,
      input  issue_done_int, issue_done_mem, issue_done_mult, issue_done_div,
             div_busy, cdb_sel_valid, cdb_sel, cdb_slot_vec
   );
endinterface

// File: rtl/issue_unit.sv
// Tomasulo issue stage: grants ready stations whose CDB result slot is free and
// keeps a shifting CDB reservation map so only one unit drives the CDB per cycle.
module issue_unit #(
   parameter int INT_LAT  = 1,
   parameter int MEM_LAT  = 2,
   parameter int MULT_LAT = 4,
   parameter int DIV_LAT  = 7
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   issue_unit_if.slave   bus
);
   localparam logic [1:0] ID_INT  = 2'd0;
   localparam logic [1:0] ID_MEM  = 2'd1;
   localparam logic [1:0] ID_MULT = 2'd2;
   localparam logic [1:0] ID_DIV  = 2'd3;

   logic [DIV_LAT:0]       slot_q, slot_d;
   logic [DIV_LAT:0][1:0]  own_q, own_d;
   logic [3:0]             div_cnt_q, div_cnt_d;

   logic gnt_int, gnt_mem, gnt_mult, gnt_div;
   logic div_busy;

   assign div_busy = (div_cnt_q != 4'd0);

   // Latencies are distinct, so concurrent grants never collide on a slot.
   always_comb begin
      gnt_int  = i_rst_n & bus.int_issue_rdy  & ~slot_q[INT_LAT];
      gnt_mem  = i_rst_n & bus.mem_issue_rdy  & ~slot_q[MEM_LAT];
      gnt_mult = i_rst_n & bus.mult_issue_rdy & ~slot_q[MULT_LAT];
      gnt_div  = i_rst_n & bus.div_issue_rdy  & ~slot_q[DIV_LAT] & ~div_busy;
   end

   always_comb begin
      slot_d = {1'b0, slot_q[DIV_LAT:1]};
      own_d  = '0;
      for (int k = 0; k < DIV_LAT; k++) begin
         own_d[k] = own_q[k+1];
      end
      // Booking slot LAT-1 of the next map means the result lands LAT cycles from now.
      if (gnt_int) begin
         slot_d[INT_LAT-1] = 1'b1;
         own_d[INT_LAT-1]  = ID_INT;
      end
      if (gnt_mem) begin
         slot_d[MEM_LAT-1] = 1'b1;
         own_d[MEM_LAT-1]  = ID_MEM;
      end
      if (gnt_mult) begin
         slot_d[MULT_LAT-1] = 1'b1;
         own_d[MULT_LAT-1]  = ID_MULT;
      end
      if (gnt_div) begin
         slot_d[DIV_LAT-1] = 1'b1;
         own_d[DIV_LAT-1]  = ID_DIV;
      end
   end

   always_comb begin
      div_cnt_d = div_cnt_q;
      if (gnt_div) begin
         div_cnt_d = 4'(DIV_LAT - 1);
      end else if (div_busy) begin
         div_cnt_d = div_cnt_q - 4'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         slot_q    <= '0;
         own_q     <= '0;
         div_cnt_q <= '0;
      end else begin
         slot_q    <= slot_d;
         own_q     <= own_d;
         div_cnt_q <= div_cnt_d;
      end
   end

   assign bus.issue_done_int  = gnt_int;
   assign bus.issue_done_mem  = gnt_mem;
   assign bus.issue_done_mult = gnt_mult;
   assign bus.issue_done_div  = gnt_div;
   assign bus.div_busy        = div_busy;
   assign bus.cdb_sel_valid   = slot_q[0];
   assign bus.cdb_sel         = slot_q[0] ? own_q[0] : 2'd0;
   assign bus.cdb_slot_vec    = slot_q;
endmodule

// File: tb/tb_issue_unit.sv
// Scoreboard bench for issue_unit: a time-indexed CDB booking model predicts each
// cycle's grants and CDB outputs; a negedge monitor pops and compares.
module tb_issue_unit;
   localparam int INT_LAT  = 1;
   localparam int MEM_LAT  = 2;
   localparam int MULT_LAT = 4;
   localparam int DIV_LAT  = 7;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   issue_unit_if #(.DIV_LAT(DIV_LAT)) bus ();

   issue_unit #(
      .INT_LAT (INT_LAT),
      .MEM_LAT (MEM_LAT),
      .MULT_LAT(MULT_LAT),
      .DIV_LAT (DIV_LAT)
   ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus)
   );

   typedef struct {
      bit               chk_state;
      logic [3:0]       gnt;
      logic             busy;
      logic             vld;
      logic [1:0]       sel;
      logic [DIV_LAT:0] vec;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Model: absolute cycle -> unit ID that owns the CDB on that cycle.
   int    book[longint];
   longint cyc       = 0;
   longint div_free  = 0;
   bit    mdl_valid  = 1'b0;
   int    lat[4]     = '{INT_LAT, MEM_LAT, MULT_LAT, DIV_LAT};

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   // rdy bits: 0=int 1=mem 2=mult 3=div
   task automatic step(input bit rst, input logic [3:0] rdy);
      exp_t e;
      logic [3:0] g;
      @(posedge clk);
      #1;
      rst_n              = rst;
      bus.int_issue_rdy  = rdy[0];
      bus.mem_issue_rdy  = rdy[1];
      bus.mult_issue_rdy = rdy[2];
      bus.div_issue_rdy  = rdy[3];
      g = '0;
      if (rst && mdl_valid) begin
         for (int i = 0; i < 4; i++) begin
            if (rdy[i] && !book.exists(cyc + lat[i]) && (i != 3 || cyc >= div_free))
               g[i] = 1'b1;
         end
      end
      e.chk_state = mdl_valid;
      e.gnt       = g;
      e.busy      = (cyc < div_free);
      e.vld       = book.exists(cyc);
      e.sel       = e.vld ? 2'(book[cyc]) : 2'd0;
      for (int k = 0; k <= DIV_LAT; k++) e.vec[k] = book.exists(cyc + k);
      exp_q.push_back(e);
      if (!rst) begin
         book.delete();
         div_free  = 0;
         mdl_valid = 1'b1;
      end else begin
         if (book.exists(cyc)) book.delete(cyc);
         for (int i = 0; i < 4; i++) if (g[i]) book[cyc + lat[i]] = i;
         if (g[3]) div_free = cyc + DIV_LAT;
      end
      cyc++;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("grants", 32'({bus.issue_done_div, bus.issue_done_mult,
                            bus.issue_done_mem, bus.issue_done_int}), 32'(e.gnt));
         if (e.chk_state) begin
            chk("div_busy", 32'(bus.div_busy), 32'(e.busy));
            chk("cdb_sel", 32'({bus.cdb_sel_valid, bus.cdb_sel}), 32'({e.vld, e.sel}));
            chk("cdb_slot_vec", 32'(bus.cdb_slot_vec), 32'(e.vec));
         end
      end
   end

   initial begin
      bus.int_issue_rdy  = 1'b1;
      bus.mem_issue_rdy  = 1'b1;
      bus.mult_issue_rdy = 1'b1;
      bus.div_issue_rdy  = 1'b1;

      repeat (3) step(1'b0, 4'hF);
      repeat (2) step(1'b1, 4'h0);
      // all four at once, results at t+1,t+2,t+4,t+7
      step(1'b1, 4'hF);
      repeat (8) step(1'b1, 4'h0);
      // mult blocks int slot one cycle
      step(1'b1, 4'b0100);
      repeat (2) step(1'b1, 4'h0);
      repeat (2) step(1'b1, 4'b0001);
      repeat (4) step(1'b1, 4'h0);
      // divider back-to-back spacing
      repeat (15) step(1'b1, 4'b1000);
      repeat (8) step(1'b1, 4'h0);
      // pipelined mult
      repeat (5) step(1'b1, 4'b0100);
      repeat (6) step(1'b1, 4'h0);
      // reset mid-flight discards bookings
      step(1'b1, 4'b1100);
      step(1'b1, 4'h0);
      step(1'b0, 4'h0);
      repeat (8) step(1'b1, 4'h0);

      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 199) != 0, 4'($urandom_range(0, 15)));
      end
      repeat (3) step(1'b1, 4'h0);

      repeat (2) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
